// File: rtl/coeff_table.sv
// Rotation coefficient table: stores {cos, sin} per entry and serves 2x2 rotation
// matrix terms through a two-stage valid/ready pipeline, with an identity sweep after reset.
module coeff_table #(
    parameter int CW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] c1,
    output logic [CW-1:0] c2,
    output logic [CW-1:0] c3,
    output logic [CW-1:0] c4,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_cos,
    input  logic [CW-1:0] wr_sin,
    output logic          wr_ready,
    output logic          init_busy
);

    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CW-1:0] Q_MAX = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] Q_MIN = {1'b1, {(CW-1){1'b0}}};

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic [2*CW-1:0] mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [2*CW-1:0] mem_wdata;

    logic            adv;
    logic            s1_valid_q;
    logic            s1_inv_q;
    logic [2*CW-1:0] s1_data_q;

    logic [CW-1:0]   s1_cos, s1_sin, s1_neg_sin;
    logic [CW-1:0]   c2_d, c3_d;

    logic            out_valid_q;
    logic [CW-1:0]   c1_q, c2_q, c3_q, c4_q;

    function automatic logic [CW-1:0] satNeg(input logic [CW-1:0] x);
        if (x == Q_MIN) begin
            return Q_MAX;
        end
        return -x;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the single write port while initialising; user writes only in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = {wr_cos, wr_sin};
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = {Q_MAX, {CW{1'b0}}};
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign adv       = !out_valid_q || out_ready;
    assign req_ready = (state_q == ST_RUN) && adv;
    assign wr_ready  = (state_q == ST_RUN);
    assign init_busy = (state_q == ST_INIT);

    // Reading the array here sees pre-edge contents, so a same-cycle write is read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= req_valid && req_ready;
            s1_inv_q   <= req_inv;
            s1_data_q  <= mem_q[req_addr];
        end
    end

    assign s1_cos     = s1_data_q[2*CW-1:CW];
    assign s1_sin     = s1_data_q[CW-1:0];
    assign s1_neg_sin = satNeg(s1_sin);
    assign c2_d       = s1_inv_q ? s1_sin : s1_neg_sin;
    assign c3_d       = s1_inv_q ? s1_neg_sin : s1_sin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            c4_q        <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            c1_q        <= s1_cos;
            c2_q        <= c2_d;
            c3_q        <= c3_d;
            c4_q        <= s1_cos;
        end
    end

    assign out_valid = out_valid_q;
    assign c1        = c1_q;
    assign c2        = c2_q;
    assign c3        = c3_q;
    assign c4        = c4_q;

endmodule

// File: tb/tb_coeff_table.sv
// Scoreboard bench for coeff_table: a table model predicts each accepted lookup,
// and a negedge monitor pops and compares whenever a result is transferred.
module tb_coeff_table;

    localparam int CW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef logic [4*CW-1:0] res_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_inv;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] c1, c2, c3, c4;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_cos;
    logic [CW-1:0] wr_sin;
    logic          wr_ready;
    logic          init_busy;

    int   nVec = 0;
    int   nMis = 0;
    res_t expQ[$];
    logic [CW-1:0] mCos [DEPTH];
    logic [CW-1:0] mSin [DEPTH];
    int   initLeft = DEPTH;
    int   curRun = 0;
    int   maxRun = 0;
    logic prevStall = 1'b0;
    res_t prevOut = '0;

    coeff_table #(.CW(CW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_inv(req_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_cos(wr_cos), .wr_sin(wr_sin),
        .wr_ready(wr_ready), .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Rotation terms straight from the math: negated sine clipped to the positive range.
    function automatic res_t refModel(input logic [15:0] cosV, input logic [15:0] sinV, input logic inv);
        int s;
        int n;
        logic [15:0] nv;
        s = $signed(sinV);
        n = -s;
        if (n > 32767) n = 32767;
        nv = n[15:0];
        return inv ? {cosV, sinV, nv, cosV} : {cosV, nv, sinV, cosV};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            initLeft  = DEPTH;
            prevStall = 1'b0;
            curRun    = 0;
            for (int i = 0; i < DEPTH; i++) begin
                mCos[i] = 16'h7FFF;
                mSin[i] = 16'h0000;
            end
        end else begin
            checkOutput("init_busy", {63'd0, init_busy}, {63'd0, initLeft > 0});
            checkOutput("wr_ready", {63'd0, wr_ready}, {63'd0, initLeft == 0});
            checkOutput("req_ready", {63'd0, req_ready},
                        {63'd0, (initLeft == 0) && (!out_valid || out_ready)});
            if (prevStall) begin
                checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
                checkOutput("hold_data", {c1, c2, c3, c4}, prevOut);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    nVec++;
                    nMis++;
                    $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", {c1, c2, c3, c4});
                end else begin
                    checkOutput("result", {c1, c2, c3, c4}, expQ.pop_front());
                end
                curRun++;
                if (curRun > maxRun) maxRun = curRun;
            end else begin
                curRun = 0;
            end
            prevStall = out_valid && !out_ready;
            prevOut   = {c1, c2, c3, c4};
            if (req_valid && req_ready) begin
                expQ.push_back(refModel(mCos[req_addr], mSin[req_addr], req_inv));
            end
            if (initLeft > 0) begin
                initLeft--;
            end else if (wr_en) begin
                mCos[wr_addr] = wr_cos;
                mSin[wr_addr] = wr_sin;
            end
        end
    end

    task automatic applyStimulus(input logic rv, input logic [3:0] ra, input logic ri,
                                 input logic we, input logic [3:0] wa,
                                 input logic [15:0] wc, input logic [15:0] ws, input logic ordy);
        @(posedge clk);
        #1;
        req_valid = rv;
        req_addr  = ra;
        req_inv   = ri;
        wr_en     = we;
        wr_addr   = wa;
        wr_cos    = wc;
        wr_sin    = ws;
        out_ready = ordy;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic countInit();
        int busyCnt;
        busyCnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!init_busy) break;
            busyCnt++;
        end
        checkOutput("init_cycles", 64'(busyCnt), 64'd16);
        checkOutput("ready_after_init", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  a;
        logic [15:0] wc, ws;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_inv = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_cos = '0; wr_sin = '0;
        out_ready = 1'b1;
        #12;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_coeffs", {c1, c2, c3, c4}, 64'd0);
        checkOutput("rst_init_busy", {63'd0, init_busy}, 64'd1);
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countInit();

        // Identity lookup with a two-edge latency check.
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        checkOutput("latency_edge1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("latency_edge2", {63'd0, out_valid}, 64'd1);
        checkOutput("addr7_identity", {c1, c2, c3, c4}, 64'h7FFF_0000_0000_7FFF);
        idle(2);

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 16'h5A82, 16'h5A82, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        idle(3);

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h1234, 16'h8000, 1'b1);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        idle(3);

        maxRun = 0;
        for (int i = 0; i < DEPTH; i++) begin
            a = 4'(i);
            applyStimulus(1'b1, a, a[0], 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        end
        idle(3);
        checkOutput("burst_run", 64'(maxRun), 64'd16);

        // Two results in flight, then the consumer stalls for three cycles.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        repeat (3) applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        idle(4);

        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 16'h4000, 16'h6ED9, 1'b1);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            wc = 16'($urandom);
            ws = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                          $urandom_range(0, 2) == 0, 4'($urandom), wc, ws,
                          $urandom_range(0, 3) != 0);
        end
        idle(4);

        // Reset with two lookups in flight; addr 3 must come back as identity.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 16'h5A82, 16'h5A82, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        wr_en = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_init_busy", {63'd0, init_busy}, 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countInit();
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_reset_addr3", {c1, c2, c3, c4}, 64'h7FFF_0000_0000_7FFF);
        idle(2);

        for (int k = 0; k < 50 && expQ.size() != 0; k++) idle(1);
        checkOutput("drain", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
